// File: rtl/snax_csr_rmw_translator.sv
// Translates SNAX accelerator CSR instructions into CSR req/rsp transactions; optional RMW for set/clear (SNAX_CSR_RMW_EN).
// Latency: 3 cycles accept->pvalid with zero-wait downstream, +2 for RMW, 1 for out-of-range errors.
// Backpressure: one transaction in flight; qready low until the core response handshake, all outputs held while stalled.

typedef struct packed {
    logic [31:0] data_op;
    logic [31:0] data_arga;
    logic [31:0] data_argb;
    logic [4:0]  id;
} snax_acc_req_t;

typedef struct packed {
    logic [31:0] data;
    logic [4:0]  id;
    logic        error;
} snax_acc_rsp_t;

module snax_csr_rmw_translator #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter logic [31:0] CsrAddrOffset = 32'h3C0,
    parameter int unsigned NumCsr        = 16,
    parameter type         acc_req_t     = snax_acc_req_t,
    parameter type         acc_rsp_t     = snax_acc_rsp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 snax_qvalid_i,
    output logic                 snax_qready_o,
    input  acc_req_t             snax_req_i,
    output acc_rsp_t             snax_resp_o,
    output logic                 snax_pvalid_o,
    input  logic                 snax_pready_i,
    output logic [DataWidth-1:0] io_csr_req_bits_data_i,
    output logic [AddrWidth-1:0] io_csr_req_bits_addr_i,
    output logic                 io_csr_req_bits_write_i,
    output logic                 io_csr_req_valid_i,
    input  logic                 io_csr_req_ready_o,
    output logic                 io_csr_rsp_ready_i,
    input  logic                 io_csr_rsp_valid_o,
    input  logic [DataWidth-1:0] io_csr_rsp_bits_data_o
);
    localparam logic [6:0] OpcodeSystem = 7'b1110011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    typedef enum logic [1:0] {CLS_READ, CLS_WRITE, CLS_SET, CLS_CLEAR} op_class_e;

    state_e               state_q, state_d;
    op_class_e            cls_q, raw_cls, acc_cls;
    logic [AddrWidth-1:0] index_q;
    logic [DataWidth-1:0] operand_q, acc_operand, wdata, rsp_capture;
    logic [AddrWidth:0]   idx_diff;
    logic [31:0]          acc_op;
    logic                 in_range, req_write, rmw_first;
    acc_rsp_t             rsp_q;
    logic                 unused_op_bits;

    assign acc_op         = snax_req_i.data_op;
    assign acc_operand    = snax_req_i.data_arga[DataWidth-1:0];
    assign unused_op_bits = ^{acc_op[31:15], acc_op[11:7]};

    // Extra MSB of the subtraction is the borrow, i.e. data_argb below the CSR window.
    assign idx_diff = {1'b0, AddrWidth'(snax_req_i.data_argb)} - {1'b0, AddrWidth'(CsrAddrOffset)};
    assign in_range = !idx_diff[AddrWidth] && (idx_diff[AddrWidth-1:0] < AddrWidth'(NumCsr));

    always_comb begin
        raw_cls = CLS_WRITE;
        if (acc_op[6:0] == OpcodeSystem) begin
            case (acc_op[14:12])
                3'b010, 3'b110: raw_cls = CLS_SET;
                3'b011, 3'b111: raw_cls = CLS_CLEAR;
                default:        raw_cls = CLS_WRITE;
            endcase
        end
    end

`ifdef SNAX_CSR_RMW_EN
    logic                 phase_q;
    logic [DataWidth-1:0] old_q;
    logic                 is_rmw;

    // Set/clear with a zero mask cannot change the CSR, so it degenerates to a plain read.
    assign acc_cls = ((raw_cls == CLS_SET || raw_cls == CLS_CLEAR) && acc_operand == '0) ? CLS_READ : raw_cls;
    assign is_rmw      = (cls_q == CLS_SET) || (cls_q == CLS_CLEAR);
    assign rmw_first   = is_rmw && !phase_q;
    assign req_write   = (cls_q == CLS_WRITE) || (is_rmw && phase_q);
    assign rsp_capture = is_rmw ? old_q : io_csr_rsp_bits_data_o;

    always_comb begin
        case (cls_q)
            CLS_SET:   wdata = old_q | operand_q;
            CLS_CLEAR: wdata = old_q & ~operand_q;
            default:   wdata = operand_q;
        endcase
    end
`else
    assign acc_cls     = (raw_cls == CLS_SET || raw_cls == CLS_CLEAR) ? CLS_READ : raw_cls;
    assign rmw_first   = 1'b0;
    assign req_write   = (cls_q == CLS_WRITE);
    assign rsp_capture = io_csr_rsp_bits_data_o;
    assign wdata       = operand_q;
`endif

    always_comb begin
        state_d            = state_q;
        snax_qready_o      = 1'b0;
        snax_pvalid_o      = 1'b0;
        io_csr_req_valid_i = 1'b0;
        io_csr_rsp_ready_i = 1'b0;
        case (state_q)
            IDLE: begin
                snax_qready_o = 1'b1;
                if (snax_qvalid_i) state_d = in_range ? REQ : RESP;
            end
            REQ: begin
                io_csr_req_valid_i = 1'b1;
                if (io_csr_req_ready_o) state_d = WAIT;
            end
            WAIT: begin
                io_csr_rsp_ready_i = 1'b1;
                if (io_csr_rsp_valid_o) state_d = rmw_first ? REQ : RESP;
            end
            RESP: begin
                snax_pvalid_o = 1'b1;
                if (snax_pready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign io_csr_req_bits_addr_i  = index_q;
    assign io_csr_req_bits_data_i  = wdata;
    assign io_csr_req_bits_write_i = req_write;
    assign snax_resp_o             = rsp_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cls_q     <= CLS_READ;
            index_q   <= '0;
            operand_q <= '0;
            rsp_q     <= '0;
`ifdef SNAX_CSR_RMW_EN
            phase_q   <= 1'b0;
            old_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && snax_qvalid_i) begin
                cls_q       <= acc_cls;
                index_q     <= idx_diff[AddrWidth-1:0];
                operand_q   <= acc_operand;
                rsp_q       <= '0;
                rsp_q.id    <= snax_req_i.id;
                rsp_q.error <= !in_range;
`ifdef SNAX_CSR_RMW_EN
                phase_q     <= 1'b0;
`endif
            end
            if (state_q == WAIT && io_csr_rsp_valid_o && !rmw_first) begin
                rsp_q.data <= rsp_capture;
            end
`ifdef SNAX_CSR_RMW_EN
            if (state_q == WAIT && io_csr_rsp_valid_o && rmw_first) begin
                old_q   <= io_csr_rsp_bits_data_o;
                phase_q <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_snax_csr_rmw_translator.sv
// Directed bench for snax_csr_rmw_translator with a transaction-level model and a per-cycle compare process.
module tb_snax_csr_rmw_translator;
`ifdef SNAX_CSR_RMW_EN
    localparam bit Rmw = 1'b1;
`else
    localparam bit Rmw = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          snax_qvalid_i;
    logic          snax_qready_o;
    snax_acc_req_t snax_req_i;
    snax_acc_rsp_t snax_resp_o;
    logic          snax_pvalid_o;
    logic          snax_pready_i;
    logic [31:0]   io_csr_req_bits_data_i;
    logic [31:0]   io_csr_req_bits_addr_i;
    logic          io_csr_req_bits_write_i;
    logic          io_csr_req_valid_i;
    logic          io_csr_req_ready_o;
    logic          io_csr_rsp_ready_i;
    logic          io_csr_rsp_valid_o;
    logic [31:0]   io_csr_rsp_bits_data_o;

    always #5 clk_i = ~clk_i;

    snax_csr_rmw_translator dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .snax_qvalid_i          (snax_qvalid_i),
        .snax_qready_o          (snax_qready_o),
        .snax_req_i             (snax_req_i),
        .snax_resp_o            (snax_resp_o),
        .snax_pvalid_o          (snax_pvalid_o),
        .snax_pready_i          (snax_pready_i),
        .io_csr_req_bits_data_i (io_csr_req_bits_data_i),
        .io_csr_req_bits_addr_i (io_csr_req_bits_addr_i),
        .io_csr_req_bits_write_i(io_csr_req_bits_write_i),
        .io_csr_req_valid_i     (io_csr_req_valid_i),
        .io_csr_req_ready_o     (io_csr_req_ready_o),
        .io_csr_rsp_ready_i     (io_csr_rsp_ready_i),
        .io_csr_rsp_valid_o     (io_csr_rsp_valid_o),
        .io_csr_rsp_bits_data_o (io_csr_rsp_bits_data_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
    } ds_t;

    int            errors = 0;
    int            checks = 0;
    ds_t           exp_ds[$];
    snax_acc_rsp_t exp_rsp[$];
    logic [31:0]   model_mem[16];
    logic [31:0]   dev_mem[16];
    bit            busy = 1'b0;
    int            rsp_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] csr_op(input logic [2:0] f3);
        return {12'h3C0, 5'd1, f3, 5'd2, 7'h73};
    endfunction

    // Transaction-level model: what downstream traffic and core response one instruction must produce.
    task automatic model_issue(input logic [31:0] op, input logic [31:0] arga, input logic [31:0] argb,
                               input logic [4:0] id);
        int            cls;  // 0 write, 1 read, 2 set, 3 clear
        logic [31:0]   idx, old, nv;
        snax_acc_rsp_t r;
        cls = 0;
        if (op[6:0] == 7'h73) begin
            case (op[14:12])
                3'd2, 3'd6: cls = 2;
                3'd3, 3'd7: cls = 3;
                default:    cls = 0;
            endcase
        end
        if (cls >= 2 && (arga == 32'd0 || !Rmw)) cls = 1;
        r.id = id; r.error = 1'b0; r.data = 32'd0;
        if (argb < 32'h3C0 || (argb - 32'h3C0) >= 32'd16) begin
            r.error = 1'b1;
            exp_rsp.push_back(r);
            return;
        end
        idx = argb - 32'h3C0;
        old = model_mem[idx[3:0]];
        case (cls)
            0: begin
                exp_ds.push_back('{idx, 1'b1, arga});
                model_mem[idx[3:0]] = arga;
            end
            1: begin
                exp_ds.push_back('{idx, 1'b0, 32'd0});
                r.data = old;
            end
            default: begin
                nv = (cls == 2) ? (old | arga) : (old & ~arga);
                exp_ds.push_back('{idx, 1'b0, 32'd0});
                exp_ds.push_back('{idx, 1'b1, nv});
                model_mem[idx[3:0]] = nv;
                r.data = old;
            end
        endcase
        exp_rsp.push_back(r);
    endtask

    // Downstream CSR device: one response per accepted request, optional response delay.
    initial begin : responder
        logic        w;
        logic [31:0] a, d;
        bit          abort, done;
        int          n;
        io_csr_rsp_valid_o     = 1'b0;
        io_csr_rsp_bits_data_o = 32'd0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && io_csr_req_valid_i && io_csr_req_ready_o) begin
                w = io_csr_req_bits_write_i; a = io_csr_req_bits_addr_i; d = io_csr_req_bits_data_i;
                abort = 1'b0; done = 1'b0; n = 0;
                @(posedge clk_i); #1;
                while (!abort && n < rsp_delay) begin
                    @(negedge clk_i);
                    if (!rst_ni) abort = 1'b1;
                    else begin @(posedge clk_i); #1; n++; end
                end
                if (!abort) begin
                    if (w) dev_mem[a[3:0]] = d;
                    io_csr_rsp_bits_data_o = w ? 32'd0 : dev_mem[a[3:0]];
                    io_csr_rsp_valid_o     = 1'b1;
                    n = 0;
                    while (!done && !abort) begin
                        @(negedge clk_i);
                        if (!rst_ni) abort = 1'b1;
                        else if (io_csr_rsp_ready_i) done = 1'b1;
                        else if (++n > 50) begin
                            checks++; errors++;
                            $display("FAIL rsp_ready_timeout: got no rsp_ready within 50 cycles, expected one");
                            abort = 1'b1;
                        end
                    end
                    @(posedge clk_i); #1;
                    io_csr_rsp_valid_o     = 1'b0;
                    io_csr_rsp_bits_data_o = 32'd0;
                end
            end
        end
    end

    // Compare process: every cycle out of reset.
    logic          prev_req_hold = 1'b0, prev_rsp_hold = 1'b0, prev_write;
    logic [31:0]   prev_addr, prev_data;
    snax_acc_rsp_t prev_rsp, cmp_r;
    ds_t           cmp_e;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_req_hold = 1'b0;
            prev_rsp_hold = 1'b0;
        end else begin
            chk("qready", 32'(snax_qready_o), 32'(!busy));
            if (!busy) begin
                chk("idle_req_valid", 32'(io_csr_req_valid_i), 32'd0);
                chk("idle_pvalid", 32'(snax_pvalid_o), 32'd0);
                chk("idle_rsp_ready", 32'(io_csr_rsp_ready_i), 32'd0);
            end
            if (prev_req_hold) begin
                chk("req_hold_valid", 32'(io_csr_req_valid_i), 32'd1);
                chk("req_hold_addr", io_csr_req_bits_addr_i, prev_addr);
                chk("req_hold_write", 32'(io_csr_req_bits_write_i), 32'(prev_write));
                chk("req_hold_data", io_csr_req_bits_data_i, prev_data);
            end
            if (prev_rsp_hold) begin
                chk("rsp_hold_valid", 32'(snax_pvalid_o), 32'd1);
                chk("rsp_hold_data", snax_resp_o.data, prev_rsp.data);
                chk("rsp_hold_id_err", {26'd0, snax_resp_o.id, snax_resp_o.error},
                    {26'd0, prev_rsp.id, prev_rsp.error});
            end
            if (io_csr_req_valid_i && io_csr_req_ready_o) begin
                if (exp_ds.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ds_req: got addr 0x%0h write %0b, expected no request",
                             io_csr_req_bits_addr_i, io_csr_req_bits_write_i);
                end else begin
                    cmp_e = exp_ds.pop_front();
                    chk("ds_addr", io_csr_req_bits_addr_i, cmp_e.addr);
                    chk("ds_write", 32'(io_csr_req_bits_write_i), 32'(cmp_e.write));
                    if (cmp_e.write) chk("ds_data", io_csr_req_bits_data_i, cmp_e.data);
                end
            end
            if (snax_pvalid_o && snax_pready_i) begin
                if (exp_rsp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_core_rsp: got data 0x%0h, expected no response", snax_resp_o.data);
                end else begin
                    cmp_r = exp_rsp.pop_front();
                    chk("rsp_data", snax_resp_o.data, cmp_r.data);
                    chk("rsp_id", 32'(snax_resp_o.id), 32'(cmp_r.id));
                    chk("rsp_error", 32'(snax_resp_o.error), 32'(cmp_r.error));
                end
            end
            prev_req_hold = io_csr_req_valid_i && !io_csr_req_ready_o;
            prev_addr     = io_csr_req_bits_addr_i;
            prev_write    = io_csr_req_bits_write_i;
            prev_data     = io_csr_req_bits_data_i;
            prev_rsp_hold = snax_pvalid_o && !snax_pready_i;
            prev_rsp      = snax_resp_o;
        end
    end

    task automatic drive_accept(input logic [31:0] op, input logic [31:0] arga, input logic [31:0] argb,
                                input logic [4:0] id, output bit ok);
        int n;
        snax_req_i    = '{data_op: op, data_arga: arga, data_argb: argb, id: id};
        snax_qvalid_i = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk_i);
            if (snax_qready_o) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got qready=0 for 20 cycles, expected 1");
            snax_qvalid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        snax_qvalid_i = 1'b0;
        snax_req_i    = '1;
        busy          = 1'b1;
    endtask

    task automatic run_op(input logic [31:0] op, input logic [31:0] arga, input logic [31:0] argb,
                          input logic [4:0] id, input int rq_stall, input int p_stall,
                          output int lat, output snax_acc_rsp_t rsp);
        int n, left;
        bit ok;
        lat = 0; rsp = '0;
        model_issue(op, arga, argb, id);
        io_csr_req_ready_o = (rq_stall == 0);
        snax_pready_i      = (p_stall == 0);
        drive_accept(op, arga, argb, id, ok);
        if (!ok) return;
        lat = 1; left = rq_stall; ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk_i);
            if (snax_pvalid_o) ok = 1'b1;
            else begin
                @(posedge clk_i); #1;
                lat++; n++;
                if (left > 0) begin
                    left--;
                    if (left == 0) io_csr_req_ready_o = 1'b1;
                end
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL pvalid_timeout: got no pvalid within 200 cycles, expected one");
            return;
        end
        if (p_stall > 0) begin
            repeat (p_stall) begin @(posedge clk_i); #1; end
            snax_pready_i = 1'b1;
            @(negedge clk_i);
        end
        rsp = snax_resp_o;
        @(posedge clk_i); #1;
        snax_pready_i      = 1'b0;
        io_csr_req_ready_o = 1'b1;
        busy               = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int            lat, n;
        bit            ok;
        snax_acc_rsp_t rsp;
        logic [31:0]   saved;
        rst_ni = 1'b0; snax_qvalid_i = 1'b0; snax_req_i = '0;
        snax_pready_i = 1'b0; io_csr_req_ready_o = 1'b1;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'h1000 + i;
            dev_mem[i]   = 32'h1000 + i;
        end
        model_mem[5] = 32'h0000_0F0F; dev_mem[5] = 32'h0000_0F0F;
        model_mem[7] = 32'h0000_00FF; dev_mem[7] = 32'h0000_00FF;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_qready", 32'(snax_qready_o), 32'd1);
        chk("reset_pvalid", 32'(snax_pvalid_o), 32'd0);
        chk("reset_req_valid", 32'(io_csr_req_valid_i), 32'd0);
        chk("reset_rsp_ready", 32'(io_csr_rsp_ready_i), 32'd0);
        chk("reset_req_fields", {31'd0, io_csr_req_bits_write_i} | io_csr_req_bits_addr_i | io_csr_req_bits_data_i, 32'd0);
        chk("reset_resp", snax_resp_o.data | {26'd0, snax_resp_o.id, snax_resp_o.error}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_op(csr_op(3'b001), 32'hDEADBEEF, 32'h3C2, 5'd3, 0, 0, lat, rsp);
        chk("csrrw_latency", 32'(lat), 32'd3);
        chk("csrrw_rsp_data", rsp.data, 32'd0);
        chk("csrrw_rsp_id", 32'(rsp.id), 32'd3);
        chk("csrrw_dev_mem", dev_mem[2], 32'hDEADBEEF);

        run_op(csr_op(3'b010), 32'h0000_00F0, 32'h3C5, 5'd4, 0, 0, lat, rsp);
        chk("csrrs_latency", 32'(lat), Rmw ? 32'd5 : 32'd3);
        chk("csrrs_rsp_data", rsp.data, 32'h0000_0F0F);
        chk("csrrs_dev_mem", dev_mem[5], Rmw ? 32'h0000_0FFF : 32'h0000_0F0F);

        run_op(csr_op(3'b011), 32'h0000_000F, 32'h3C7, 5'd5, 0, 0, lat, rsp);
        chk("csrrc_rsp_data", rsp.data, 32'h0000_00FF);
        chk("csrrc_dev_mem", dev_mem[7], Rmw ? 32'h0000_00F0 : 32'h0000_00FF);

        run_op(csr_op(3'b010), 32'd0, 32'h3C5, 5'd6, 0, 0, lat, rsp);
        chk("csrrs_zero_latency", 32'(lat), 32'd3);
        chk("csrrs_zero_rsp_data", rsp.data, Rmw ? 32'h0000_0FFF : 32'h0000_0F0F);

        run_op(csr_op(3'b110), 32'h0000_0100, 32'h3C2, 5'd7, 0, 0, lat, rsp);
        chk("csrrsi_rsp_data", rsp.data, 32'hDEADBEEF);
        run_op(csr_op(3'b111), 32'h0000_000F, 32'h3C2, 5'd11, 0, 0, lat, rsp);
        chk("csrrci_rsp_data", rsp.data, Rmw ? 32'hDEADBFEF : 32'hDEADBEEF);

        run_op(csr_op(3'b001), 32'h1234_5678, 32'h3D0, 5'd8, 0, 0, lat, rsp);
        chk("oor_latency", 32'(lat), 32'd1);
        chk("oor_error", 32'(rsp.error), 32'd1);
        chk("oor_data", rsp.data, 32'd0);
        run_op(csr_op(3'b010), 32'h0000_0001, 32'h100, 5'd9, 0, 0, lat, rsp);
        chk("underflow_error", 32'(rsp.error), 32'd1);
        chk("underflow_id", 32'(rsp.id), 32'd9);

        run_op({25'd0, 7'h0B}, 32'h0000_1234, 32'h3CF, 5'd12, 0, 0, lat, rsp);
        chk("other_op_dev_mem", dev_mem[15], 32'h0000_1234);

        run_op(csr_op(3'b001), 32'h0000_A5A5, 32'h3C3, 5'd13, 5, 3, lat, rsp);
        chk("stall_latency", 32'(lat), 32'd8);
        chk("stall_dev_mem", dev_mem[3], 32'h0000_A5A5);
        run_op(csr_op(3'b010), 32'hF000_0000, 32'h3C9, 5'd14, 5, 3, lat, rsp);
        chk("stall_rmw_rsp_data", rsp.data, 32'h0000_1009);

        // Reset while waiting for the first downstream response.
        saved = model_mem[1];
        model_issue(csr_op(3'b010), 32'h0000_0010, 32'h3C1, 5'd10);
        rsp_delay = 3;
        io_csr_req_ready_o = 1'b1;
        drive_accept(csr_op(3'b010), 32'h0000_0010, 32'h3C1, 5'd10, ok);
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk_i);
            if (io_csr_rsp_ready_i) ok = 1'b1;
            else n++;
        end
        chk("reach_wait", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("midrst_qready", 32'(snax_qready_o), 32'd1);
        chk("midrst_valids", {29'd0, snax_pvalid_o, io_csr_req_valid_i, io_csr_rsp_ready_i}, 32'd0);
        model_mem[1] = saved;
        exp_ds.delete();
        exp_rsp.delete();
        busy      = 1'b0;
        rsp_delay = 0;
        rst_ni    = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        run_op(csr_op(3'b001), 32'h0000_0077, 32'h3C1, 5'd15, 0, 0, lat, rsp);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_id", 32'(rsp.id), 32'd15);
        chk("post_rst_dev_mem", dev_mem[1], 32'h0000_0077);

        repeat (3) @(posedge clk_i);
        chk("ds_queue_drained", 32'(exp_ds.size()), 32'd0);
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snax_csr_rmw_translator.md
Name: snax_csr_rmw_translator

Overview:
- Parametrised successor to the SNAX core-to-CSR-manager translator.
- Accepts SNAX accelerator CSR instructions and converts them into simplified CSR request/response transactions.
- Registers each transaction. Runs a read-modify-write sequence for CSRRS/CSRRC-class ops, range-checks the CSR address, and returns an error response for out-of-range accesses.
- Sits between the Snitch accelerator port and an accelerator CSR manager.

Parameters:
- DataWidth, 32, CSR data width (bits).
- AddrWidth, 32, downstream CSR address width.
- CsrAddrOffset, 32'h3C0, subtracted from data_argb to form the CSR index.
- NumCsr, 16, CSR count; indices >= NumCsr are out of range.
- acc_req_t, logic, request struct with fields data_op, data_arga, data_argb, id.
- acc_rsp_t, logic, response struct with fields data, id, error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- snax_qvalid_i  in  1  core request valid
- snax_qready_o  out  1  core request ready
- snax_req_i  in  acc_req_t  core request
- snax_resp_o  out  acc_rsp_t  core response
- snax_pvalid_o  out  1  core response valid
- snax_pready_i  in  1  core response ready
- io_csr_req_bits_data_i  out  DataWidth  write data
- io_csr_req_bits_addr_i  out  AddrWidth  CSR index
- io_csr_req_bits_write_i  out  1  1 = write, 0 = read
- io_csr_req_valid_i  out  1  downstream request valid
- io_csr_req_ready_o  in  1  downstream request ready
- io_csr_rsp_ready_i  out  1  downstream response ready
- io_csr_rsp_valid_o  in  1  downstream response valid
- io_csr_rsp_bits_data_o  in  DataWidth  downstream response data

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values: all outputs 0 except snax_qready_o = 1. State = IDLE; latched fields = 0.
- Op classes, decoded on accept:
  - CSRRW/CSRRWI -> WRITE.
  - CSRRS/CSRRSI -> SET.
  - CSRRC/CSRRCI -> CLEAR.
  - All other ops -> WRITE.
  - SET/CLEAR with operand data_arga[DataWidth-1:0] == 0 -> READ.
- Index = data_argb - CsrAddrOffset, computed at AddrWidth. Out of range if the subtraction underflows (data_argb < CsrAddrOffset) or index >= NumCsr.
- Downstream contract: exactly one response per accepted downstream request, reads and writes alike. Only one transaction is in flight at a time.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - snax_qready_o = 1.
  - On qvalid & qready, latch id, class, index and operand.
  - In range -> REQ, phase = 0. Out of range -> RESP with error = 1, data = 0; no downstream request is issued.
- REQ:
  - io_csr_req_valid_i = 1, held stable until io_csr_req_ready_o.
  - write = 1 for WRITE, or for SET/CLEAR in phase 1. Otherwise write = 0 (READ, or SET/CLEAR phase 0).
  - Write data: WRITE -> operand; SET -> old | operand; CLEAR -> old & ~operand.
  - On handshake -> WAIT.
- WAIT:
  - io_csr_rsp_ready_i = 1.
  - On rsp_valid with SET/CLEAR in phase 0: old <= rsp data, phase = 1, -> REQ.
  - Otherwise: capture response data (SET/CLEAR return old, not the write response) -> RESP.
- RESP:
  - snax_pvalid_o = 1 with data, latched id and error, all held stable until snax_pready_i.
  - On handshake -> IDLE.
- Latency: minimum 3 cycles from accept to pvalid for single-phase ops with zero-wait downstream (accept, REQ, WAIT). RMW adds 2 cycles.
- Core may not issue a new request before the previous response completes; qready_o = 0 outside IDLE.
- Reset mid-operation: any state -> IDLE at the next edge; in-flight transaction dropped; all valids 0.
- Downstream response arriving outside WAIT: ignored (rsp_ready = 0).

Optional Feature:
- Macro SNAX_CSR_RMW_EN.
- Defined: SET/CLEAR execute the read-modify-write sequence described above.
- Undefined: SET/CLEAR are treated as READ (single read, no write), matching legacy behaviour. The phase register and old-value register are removed.

Test Plan:
- CSRRW, argb = 0x3C2, arga = 0xDEADBEEF, downstream always ready, rsp data 0 -> one write (addr 2, data 0xDEADBEEF); core rsp data 0, error 0, id echoed; pvalid 3 cycles after accept.
- CSRRS, argb = 0x3C5, arga = 0x0000_00F0, CSR holds 0x0000_0F0F -> read addr 5, then write 0x0000_0FFF; core rsp data 0x0000_0F0F.
- CSRRC, arga = 0xF, CSR holds 0xFF -> write 0xF0; core rsp 0xFF. CSRRS with arga = 0 -> single read only, no write issued.
- argb = 0x3D0 (index 16, NumCsr = 16) and argb = 0x100 (underflow) -> no downstream valid; rsp error = 1, data = 0.
- Back-pressure: req_ready low 5 cycles, then pready low 3 cycles -> req fields stable throughout; qready stays 0 until the response handshake completes.
- rst_ni low during WAIT of a RMW sequence -> all valids 0 and qready 1 after the edge; the following CSRRW completes normally.
